fetch_queue: RTL and testbench

- Sits between fetch_block and the decode stage.
- Accepts the fetch PC, issues in-order instruction-memory requests, and buffers up to DEPTH outstanding or returned instructions with their PCs.
- Presents instructions to decode through a valid/ready handshake.
- Handles pipeline flush (branch/jump redirect) by discarding all buffered entries and all in-flight memory responses.

---
 rtl/fetch_queue.sv | 168 ++++++++++++++++
 tb/tb_fetch_queue.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction fetch buffer between fetch_block and decode.
// Accepts the fetch PC, issues word-aligned instruction-memory requests,
// buffers up to DEPTH outstanding or returned instructions with their PCs,
// and presents them to decode through a valid/ready handshake. A flush
// discards every buffered entry and every response still in flight.
//
// Ports:
//   clock, reset          - single clock; synchronous active-high reset
//   fetch_pc/fetch_accept - PC from fetch_block / PC consumed this cycle
//   imem_req_*            - request channel (valid/ready/addr)
//   imem_resp_*           - response channel (always accepted, in order)
//   flush                 - redirect; drop all state and in-flight responses
//   dec_*                 - head instruction, PC and fault flag to decode
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            fetch_accept,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            imem_resp_err,
  input  logic            flush,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic            dec_fault
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  // One extra bit: a second flush while old responses are still being
  // drained can push the pending-drop total past DEPTH.
  localparam int unsigned DW = PW + 2;

  logic [XLEN-1:0]  pc_q    [DEPTH];
  logic [XLEN-1:0]  pc_d    [DEPTH];
  logic [XLEN-1:0]  instr_q [DEPTH];
  logic [XLEN-1:0]  instr_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [DEPTH-1:0] fault_q,  fault_d;

  logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0] fill_ptr_q,  fill_ptr_d;
  logic [PW-1:0] head_ptr_q,  head_ptr_d;
  logic [CW-1:0] count_q,     count_d;
  logic [DW-1:0] drop_cnt_q,  drop_cnt_d;

  logic [CW-1:0] filled_cnt;
  logic [CW-1:0] unfilled_cnt;
  logic [DW-1:0] drop_sum;
  logic          do_alloc, do_pop, resp_drop, resp_fill;

  // Request side uses the registered count, so a full queue cannot allocate
  // in the same cycle it pops.
  assign imem_req_valid = !reset && !flush && (count_q < CW'(DEPTH));
  assign imem_req_addr  = {fetch_pc[XLEN-1:2], 2'b00};
  assign fetch_accept   = imem_req_valid && imem_req_ready;

  assign dec_valid = !reset && !flush && (count_q != '0) && filled_q[head_ptr_q];
  assign dec_instr = reset ? '0 : instr_q[head_ptr_q];
  assign dec_pc    = reset ? '0 : pc_q[head_ptr_q];
  assign dec_fault = reset ? 1'b0 : fault_q[head_ptr_q];

  // Filled bits are only ever set on live entries, so count minus the
  // popcount gives the requests still awaiting a response, even when full.
  always_comb begin
    filled_cnt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      filled_cnt = filled_cnt + CW'(filled_q[i]);
    end
    unfilled_cnt = count_q - filled_cnt;
    drop_sum     = drop_cnt_q + DW'(unfilled_cnt);
  end

  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    filled_d    = filled_q;
    fault_d     = fault_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    count_d     = count_q;
    drop_cnt_d  = drop_cnt_q;

    do_alloc  = fetch_accept;
    do_pop    = dec_valid && dec_ready;
    resp_drop = imem_resp_valid && (drop_cnt_q != '0);
    resp_fill = imem_resp_valid && (drop_cnt_q == '0) && (unfilled_cnt != '0);

    if (flush) begin
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      count_d     = '0;
      filled_d    = '0;
      // Everything requested but not yet returned must be discarded later;
      // a response arriving right now is one of those and is consumed here.
      if (imem_resp_valid && (drop_sum != '0)) begin
        drop_cnt_d = drop_sum - DW'(1);
      end else begin
        drop_cnt_d = drop_sum;
      end
    end else begin
      if (do_alloc) begin
        pc_d[alloc_ptr_q]     = fetch_pc;
        filled_d[alloc_ptr_q] = 1'b0;
        fault_d[alloc_ptr_q]  = (fetch_pc[1:0] != 2'b00);
        alloc_ptr_d           = alloc_ptr_q + PW'(1);
      end
      if (resp_drop) begin
        drop_cnt_d = drop_cnt_q - DW'(1);
      end
      if (resp_fill) begin
        instr_d[fill_ptr_q]  = imem_resp_data;
        fault_d[fill_ptr_q]  = fault_q[fill_ptr_q] | imem_resp_err;
        filled_d[fill_ptr_q] = 1'b1;
        fill_ptr_d           = fill_ptr_q + PW'(1);
      end
      if (do_pop) begin
        filled_d[head_ptr_q] = 1'b0;
        head_ptr_d           = head_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_alloc) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
      filled_q    <= '0;
      fault_q     <= '0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
      drop_cnt_q  <= '0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      filled_q    <= filled_d;
      fault_q     <= fault_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      count_q     <= count_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // A response with nothing outstanding and nothing to drop is a memory-side
  // protocol violation; the RTL ignores it.
  always_ff @(posedge clock) begin
    assert (reset || !imem_resp_valid || (drop_cnt_q != '0) || (unfilled_cnt != '0))
      else $error("fetch_queue: unexpected imem response");
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue (DEPTH=4).
// A small in-order memory model returns word 0xC0DE_0000 | addr[15:0] a
// programmable number of cycles after each accepted request.
module tb_fetch_queue;

  logic        clock;
  logic        reset;
  logic [31:0] fetch_pc;
  logic        fetch_accept;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_fault;

  fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clock           (clock),
    .reset           (reset),
    .fetch_pc        (fetch_pc),
    .fetch_accept    (fetch_accept),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .flush           (flush),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc),
    .dec_fault       (dec_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_mem();
    if (reset || mq.size() == 0 || mq[0].due > cyc) begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      imem_resp_err   = 1'b0;
    end else begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hC0DE_0000 | {16'h0000, mq[0].addr[15:0]};
      imem_resp_err   = (mq[0].addr == err_addr);
    end
  endtask

  // Samples the settled cycle, advances one clock, updates the memory model.
  task automatic tick();
    logic        acc, rv, rst;
    logic [31:0] a;
    mreq_t       r;
    acc = fetch_accept;
    rv  = imem_resp_valid;
    rst = reset;
    a   = imem_req_addr;
    @(posedge clock);
    cyc++;
    if (rst) begin
      mq.delete();
    end else begin
      if (rv) void'(mq.pop_front());
      if (acc) begin
        r.addr = a;
        r.due  = cyc - 1 + lat;
        mq.push_back(r);
      end
    end
    #1;
    drive_mem();
  endtask

  task automatic set_in(input logic rst, input logic [31:0] pc, input logic rdy,
                        input logic fl, input logic dr);
    reset          = rst;
    fetch_pc       = pc;
    imem_req_ready = rdy;
    flush          = fl;
    dec_ready      = dr;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    imem_resp_err   = 1'b0;

    // Reset
    set_in(1, 32'h0, 0, 0, 0);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_dec_valid", dec_valid, 0);
    tick();
    set_in(1, 32'h0, 0, 0, 0);
    tick();
    set_in(0, 32'h0, 0, 0, 0);
    check("post_rst_dec_valid", dec_valid, 0);
    check("post_rst_dec_pc", dec_pc, 32'h0);
    check("post_rst_dec_instr", dec_instr, 32'h0);
    check("post_rst_dec_fault", dec_fault, 0);
    check("post_rst_count", dut.count_q, 0);
    check("post_rst_req_valid", imem_req_valid, 1);

    // Streaming, k=1
    lat = 1;
    for (int i = 0; i < 7; i++) begin
      set_in(0, 32'(i * 4), (i < 4), 0, 1);
      check("stream_accept", fetch_accept, 32'(i < 4));
      if (i >= 2 && i <= 5) begin
        check("stream_dec_valid", dec_valid, 1);
        check("stream_dec_pc", dec_pc, 32'((i - 2) * 4));
        check("stream_dec_instr", dec_instr, 32'hC0DE_0000 + 32'((i - 2) * 4));
      end else begin
        check("stream_dec_idle", dec_valid, 0);
      end
      tick();
    end
    check("stream_count_end", dut.count_q, 0);

    // Full queue with decode stalled
    for (int i = 0; i < 5; i++) begin
      set_in(0, 32'(i * 4), 1, 0, 0);
      check("full_accept", fetch_accept, 32'(i < 4));
      tick();
    end
    set_in(0, 32'h10, 1, 0, 0);
    check("full_count", dut.count_q, 4);
    check("full_req_valid", imem_req_valid, 0);
    set_in(0, 32'h10, 1, 0, 1);
    check("full_pop_req_valid", imem_req_valid, 0);
    check("full_pop_dec_valid", dec_valid, 1);
    check("full_pop_dec_pc", dec_pc, 32'h0);
    tick();
    set_in(0, 32'h10, 1, 0, 1);
    check("full_reissue_accept", fetch_accept, 1);
    check("full_reissue_addr", imem_req_addr, 32'h10);
    check("full_dec_pc1", dec_pc, 32'h4);
    tick();
    set_in(0, 32'h14, 0, 0, 1);
    check("full_dec_pc2", dec_pc, 32'h8);
    tick();
    set_in(0, 32'h14, 0, 0, 1);
    check("full_dec_pc3", dec_pc, 32'hC);
    tick();
    set_in(0, 32'h14, 0, 0, 1);
    check("full_dec_pc4", dec_pc, 32'h10);
    check("full_dec_instr4", dec_instr, 32'hC0DE_0010);
    tick();
    set_in(0, 32'h14, 0, 0, 0);
    check("full_drained", dec_valid, 0);

    // Flush with two requests in flight, k=3
    lat = 3;
    set_in(0, 32'h10, 1, 0, 1);
    check("fl1_accept0", fetch_accept, 1);
    tick();
    set_in(0, 32'h14, 1, 0, 1);
    check("fl1_accept1", fetch_accept, 1);
    tick();
    set_in(0, 32'h100, 1, 1, 1);
    check("fl1_flush_no_req", imem_req_valid, 0);
    check("fl1_flush_no_dec", dec_valid, 0);
    tick();
    set_in(0, 32'h100, 1, 0, 1);
    check("fl1_drop2", dut.drop_cnt_q, 2);
    check("fl1_new_accept", fetch_accept, 1);
    tick();
    set_in(0, 32'h104, 0, 0, 1);
    check("fl1_drop1", dut.drop_cnt_q, 1);
    check("fl1_no_dec_a", dec_valid, 0);
    tick();
    set_in(0, 32'h104, 0, 0, 1);
    check("fl1_drop0", dut.drop_cnt_q, 0);
    check("fl1_no_dec_b", dec_valid, 0);
    tick();
    set_in(0, 32'h104, 0, 0, 1);
    check("fl1_no_dec_c", dec_valid, 0);
    tick();
    set_in(0, 32'h104, 0, 0, 1);
    check("fl1_dec_valid", dec_valid, 1);
    check("fl1_dec_pc", dec_pc, 32'h100);
    check("fl1_dec_instr", dec_instr, 32'hC0DE_0100);
    tick();
    set_in(0, 32'h104, 0, 0, 1);
    check("fl1_empty", dec_valid, 0);

    // Flush coinciding with the first response
    set_in(0, 32'h10, 1, 0, 1);
    tick();
    set_in(0, 32'h14, 1, 0, 1);
    tick();
    set_in(0, 32'h18, 0, 0, 1);
    tick();
    set_in(0, 32'h200, 0, 1, 1);
    check("fl2_resp_in_flush", imem_resp_valid, 1);
    tick();
    set_in(0, 32'h200, 1, 0, 1);
    check("fl2_drop1", dut.drop_cnt_q, 1);
    check("fl2_accept", fetch_accept, 1);
    tick();
    set_in(0, 32'h204, 0, 0, 1);
    check("fl2_drop0", dut.drop_cnt_q, 0);
    tick();
    set_in(0, 32'h204, 0, 0, 1);
    check("fl2_no_dec_a", dec_valid, 0);
    tick();
    set_in(0, 32'h204, 0, 0, 1);
    check("fl2_no_dec_b", dec_valid, 0);
    tick();
    set_in(0, 32'h204, 0, 0, 1);
    check("fl2_dec_valid", dec_valid, 1);
    check("fl2_dec_pc", dec_pc, 32'h200);
    check("fl2_dec_instr", dec_instr, 32'hC0DE_0200);
    tick();

    // Faults: misaligned PC, then memory access error
    lat = 1;
    set_in(0, 32'h22, 1, 0, 0);
    check("fault_addr_align", imem_req_addr, 32'h20);
    check("fault_accept", fetch_accept, 1);
    tick();
    set_in(0, 32'h22, 0, 0, 0);
    tick();
    set_in(0, 32'h22, 0, 0, 1);
    check("fault_mis_valid", dec_valid, 1);
    check("fault_mis_pc", dec_pc, 32'h22);
    check("fault_mis_flag", dec_fault, 1);
    check("fault_mis_instr", dec_instr, 32'hC0DE_0020);
    tick();
    err_addr = 32'h40;
    set_in(0, 32'h40, 1, 0, 1);
    check("fault_err_accept", fetch_accept, 1);
    tick();
    set_in(0, 32'h44, 0, 0, 1);
    tick();
    set_in(0, 32'h44, 0, 0, 1);
    check("fault_err_valid", dec_valid, 1);
    check("fault_err_pc", dec_pc, 32'h40);
    check("fault_err_flag", dec_fault, 1);
    tick();
    err_addr = 32'hFFFF_FFFF;

    // Reset with three entries buffered
    for (int i = 0; i < 3; i++) begin
      set_in(0, 32'(i * 4), 1, 0, 0);
      tick();
    end
    set_in(0, 32'hC, 0, 0, 0);
    check("mrst_count3", dut.count_q, 3);
    tick();
    set_in(1, 32'hC, 0, 0, 0);
    check("mrst_req_valid", imem_req_valid, 0);
    check("mrst_dec_valid", dec_valid, 0);
    check("mrst_dec_pc", dec_pc, 32'h0);
    tick();
    set_in(0, 32'h300, 1, 0, 1);
    check("mrst_after_dec_valid", dec_valid, 0);
    check("mrst_after_count", dut.count_q, 0);
    check("mrst_after_dec_pc", dec_pc, 32'h0);
    check("mrst_resume_accept", fetch_accept, 1);
    tick();
    set_in(0, 32'h304, 0, 0, 1);
    check("mrst_resume_wait", dec_valid, 0);
    tick();
    set_in(0, 32'h304, 0, 0, 1);
    check("mrst_resume_valid", dec_valid, 1);
    check("mrst_resume_pc", dec_pc, 32'h300);
    check("mrst_resume_instr", dec_instr, 32'hC0DE_0300);
    tick();
    set_in(0, 32'h304, 0, 0, 1);
    check("mrst_resume_empty", dec_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
